glb_start_irq_ctrl: RTL
=======================

// Module: glb_start_irq_ctrl
// PURPOSE
//  Control-side neighbour of the GLB tiles. Turns register writes into one-cycle
//  strm_start_pulse/pc_start_pulse per tile, which feed each tile's start inputs.
//  Collects each tile's strm_f2g/strm_g2f/pcfg_g2f interrupt pulses into sticky
//  W1C status registers, tracks per-tile busy, and drives one level interrupt to the host.
// PARAMETERS
//  NUM_GLB_TILES    16  tiles served; width of every per-tile vector
//  CFG_ADDR_WIDTH   4   word address width of the register port
//  CFG_DATA_WIDTH   32  register data width; must be >= NUM_GLB_TILES
// PORTS
//  clk                       in   1               clock
//  reset                     in   1               asynchronous, active-high reset
//  cfg_wr_en                 in   1               register write strobe
//  cfg_wr_addr               in   CFG_ADDR_WIDTH  write word address
//  cfg_wr_data               in   CFG_DATA_WIDTH  write data
//  cfg_rd_en                 in   1               register read strobe
//  cfg_rd_addr               in   CFG_ADDR_WIDTH  read word address
//  cfg_rd_data               out  CFG_DATA_WIDTH  read data
//  cfg_rd_data_valid         out  1               read data qualifier
//  strm_start_pulse          out  NUM_GLB_TILES   per-tile stream start, 1 cycle
//  pc_start_pulse            out  NUM_GLB_TILES   per-tile parallel-config start, 1 cycle
//  strm_f2g_interrupt_pulse  in   NUM_GLB_TILES   per-tile f2g done pulse
//  strm_g2f_interrupt_pulse  in   NUM_GLB_TILES   per-tile g2f done pulse
//  pcfg_g2f_interrupt_pulse  in   NUM_GLB_TILES   per-tile pcfg done pulse
//  interrupt                 out  1               aggregated level interrupt
// BEHAVIOUR
//  Reset: all registers, outputs, cfg_rd_data, cfg_rd_data_valid, start pulses and interrupt are 0.
//  Register map (word addr; bits above NUM_GLB_TILES read 0, ignore writes):
//   0x0 IER        RW  [2:0] enable {pcfg, g2f, f2g}
//   0x1 ISR        RO  [2:0] {|PCFG_ST, |G2F_ST, |F2G_ST}, unmasked
//   0x2 F2G_ST     W1C per-tile sticky f2g done
//   0x3 G2F_ST     W1C per-tile sticky g2f done
//   0x4 PCFG_ST    W1C per-tile sticky pcfg done
//   0x5 STRM_START WO  write-1 requests a stream start per tile; reads 0
//   0x6 PC_START   WO  write-1 requests a pc start per tile; reads 0
//   0x7 STRM_BUSY  RO  per-tile stream busy
//   0x8 PC_BUSY    RO  per-tile pc busy
//   others: reads 0; writes have no effect
//  Reads: rd_en at cycle N -> cfg_rd_data/valid at N+1 reflect register state at N.
//   Valid is 1 for exactly one cycle; data returns to 0 when valid is low.
//  Starts: write at N with bit t=1 and tile t not busy -> start_pulse[t]=1 at N+1 only.
//   At the same edge, busy[t] is set. If tile t is already busy, the request is dropped
//   (no pulse, no state change).
//  Busy clear: strm_busy[t] clears on strm_f2g[t] | strm_g2f[t]; pc_busy[t] clears on pcfg_g2f[t].
//   Start accepted in the same cycle as a done pulse for that tile: start wins; busy stays 1.
//  Status: interrupt pulse at N sets the status bit, visible from N+1.
//   Set and W1C on the same bit in the same cycle: set wins, bit = 1.
//  interrupt (registered) = |(IER & ISR) from the previous cycle; stays high until all
//   enabled sources are cleared or masked. Masking does not clear status.
//  Write and read in the same cycle are independent. A read of a W1C register in the
//   same cycle as its write returns the pre-write value.
//  Reset mid-operation: busy, status and outputs clear at once. In-flight tile pulses
//   arriving after reset release are recorded normally.
// TESTING
//  Reset: after release, all outputs are 0; reading 0x0-0x8 returns 0.
//  Write 0x5=0x0005 -> strm_start_pulse=0x0005 for one cycle. STRM_BUSY reads 0x0005.
//   Writing 0x5=0x0001 again -> no pulse.
//  IER=0x1; f2g pulse on tile 2 -> F2G_ST=0x4, interrupt=1 two cycles after the pulse,
//   STRM_BUSY bit2 clears. Write 0x2=0x4 -> interrupt falls to 0.
//  pcfg pulse on tile 3 in the same cycle as W1C 0x4=0x8 -> PCFG_ST stays 0x8.
//  IER=0 with G2F_ST=0xFFFF -> interrupt=0 and ISR=0x2. Setting IER=0x2 -> interrupt=1.
//  PC start on tile 0 in the same cycle as its pcfg done -> pc_start_pulse[0]=1 and PC_BUSY[0]=1.
//   Assert reset mid-run -> all clear asynchronously.

Source files
------------

// File: rtl/glb_start_irq_ctrl_if.sv
// ----------------------------------------------------------------------------
// glb_start_irq_ctrl_if
//   Bundles the register port, the per-tile start pulses, the per-tile done
//   pulses and the host interrupt of glb_start_irq_ctrl.
//   slave  modport : the controller (drives read data, start pulses, interrupt)
//   master modport : host + tiles (drive register accesses and done pulses)
// Signals
//   cfg_wr_en / cfg_wr_addr / cfg_wr_data   register write strobe, address, data
//   cfg_rd_en / cfg_rd_addr                 register read strobe, address
//   cfg_rd_data / cfg_rd_data_valid         read data, one cycle after the strobe
//   strm_start_pulse / pc_start_pulse       per-tile one-cycle start requests
//   strm_f2g_/strm_g2f_/pcfg_g2f_interrupt_pulse  per-tile done pulses
//   interrupt                               aggregated level interrupt to host
// ----------------------------------------------------------------------------
interface glb_start_irq_ctrl_if #(
    parameter int NUM_GLB_TILES  = 16,
    parameter int CFG_ADDR_WIDTH = 4,
    parameter int CFG_DATA_WIDTH = 32
);
    logic                      cfg_wr_en;
    logic [CFG_ADDR_WIDTH-1:0] cfg_wr_addr;
    logic [CFG_DATA_WIDTH-1:0] cfg_wr_data;
    logic                      cfg_rd_en;
    logic [CFG_ADDR_WIDTH-1:0] cfg_rd_addr;
    logic [CFG_DATA_WIDTH-1:0] cfg_rd_data;
    logic                      cfg_rd_data_valid;
    logic [NUM_GLB_TILES-1:0]  strm_start_pulse;
    logic [NUM_GLB_TILES-1:0]  pc_start_pulse;
    logic [NUM_GLB_TILES-1:0]  strm_f2g_interrupt_pulse;
    logic [NUM_GLB_TILES-1:0]  strm_g2f_interrupt_pulse;
    logic [NUM_GLB_TILES-1:0]  pcfg_g2f_interrupt_pulse;
    logic                      interrupt;

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data,
        input  cfg_rd_en, cfg_rd_addr,
        output cfg_rd_data, cfg_rd_data_valid,
        output strm_start_pulse, pc_start_pulse,
        input  strm_f2g_interrupt_pulse, strm_g2f_interrupt_pulse, pcfg_g2f_interrupt_pulse,
        output interrupt
    );

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data,
        output cfg_rd_en, cfg_rd_addr,
        input  cfg_rd_data, cfg_rd_data_valid,
        input  strm_start_pulse, pc_start_pulse,
        output strm_f2g_interrupt_pulse, strm_g2f_interrupt_pulse, pcfg_g2f_interrupt_pulse,
        input  interrupt
    );
endinterface

// File: rtl/glb_start_irq_ctrl.sv
// ----------------------------------------------------------------------------
// glb_start_irq_ctrl
//   Converts register writes into one-cycle per-tile stream / parallel-config
//   start pulses, tracks per-tile busy, captures per-tile done pulses into
//   sticky write-1-to-clear status registers and drives one level interrupt.
// Ports
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    glb_start_irq_ctrl_if.slave (register port, start/done pulses, irq)
// Register map (word address)
//   0 IER  1 ISR  2 F2G_ST  3 G2F_ST  4 PCFG_ST  5 STRM_START  6 PC_START
//   7 STRM_BUSY  8 PC_BUSY ; anything else reads 0 and ignores writes
// ----------------------------------------------------------------------------
module glb_start_irq_ctrl #(
    parameter int NUM_GLB_TILES  = 16,
    parameter int CFG_ADDR_WIDTH = 4,
    parameter int CFG_DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    glb_start_irq_ctrl_if.slave  bus
);
    localparam int N = NUM_GLB_TILES;
    localparam int AW = CFG_ADDR_WIDTH;

    typedef logic [N-1:0] tile_vec_t;

    localparam logic [AW-1:0] ADDR_IER        = AW'(0);
    localparam logic [AW-1:0] ADDR_ISR        = AW'(1);
    localparam logic [AW-1:0] ADDR_F2G_ST     = AW'(2);
    localparam logic [AW-1:0] ADDR_G2F_ST     = AW'(3);
    localparam logic [AW-1:0] ADDR_PCFG_ST    = AW'(4);
    localparam logic [AW-1:0] ADDR_STRM_START = AW'(5);
    localparam logic [AW-1:0] ADDR_PC_START   = AW'(6);
    localparam logic [AW-1:0] ADDR_STRM_BUSY  = AW'(7);
    localparam logic [AW-1:0] ADDR_PC_BUSY    = AW'(8);

    // State
    logic [2:0]                ier_q,        ier_d;
    tile_vec_t                 f2g_st_q,     f2g_st_d;
    tile_vec_t                 g2f_st_q,     g2f_st_d;
    tile_vec_t                 pcfg_st_q,    pcfg_st_d;
    tile_vec_t                 strm_busy_q,  strm_busy_d;
    tile_vec_t                 pc_busy_q,    pc_busy_d;
    tile_vec_t                 strm_start_q, strm_start_d;
    tile_vec_t                 pc_start_q,   pc_start_d;
    logic [CFG_DATA_WIDTH-1:0] rd_data_q,    rd_data_d;
    logic                      rd_valid_q,   rd_valid_d;
    logic                      irq_q,        irq_d;

    // Decode helpers
    tile_vec_t                 wr_tiles;
    tile_vec_t                 strm_req, pc_req;
    tile_vec_t                 f2g_w1c, g2f_w1c, pcfg_w1c;
    logic [2:0]                isr;
    logic [CFG_DATA_WIDTH-1:0] rd_mux;

    // NOTE: every variable driven here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_tiles  = bus.cfg_wr_data[N-1:0];
        strm_req  = '0;
        pc_req    = '0;
        f2g_w1c   = '0;
        g2f_w1c   = '0;
        pcfg_w1c  = '0;
        ier_d     = ier_q;

        if (bus.cfg_wr_en) begin
            case (bus.cfg_wr_addr)
                ADDR_IER:        ier_d    = bus.cfg_wr_data[2:0];
                ADDR_F2G_ST:     f2g_w1c  = wr_tiles;
                ADDR_G2F_ST:     g2f_w1c  = wr_tiles;
                ADDR_PCFG_ST:    pcfg_w1c = wr_tiles;
                ADDR_STRM_START: strm_req = wr_tiles;
                ADDR_PC_START:   pc_req   = wr_tiles;
                default: ;
            endcase
        end

        // A request for a busy tile is silently dropped.
        strm_start_d = strm_req & ~strm_busy_q;
        pc_start_d   = pc_req   & ~pc_busy_q;

        // An accepted start overrides a done pulse arriving in the same cycle.
        strm_busy_d = (strm_busy_q & ~(bus.strm_f2g_interrupt_pulse | bus.strm_g2f_interrupt_pulse))
                      | strm_start_d;
        pc_busy_d   = (pc_busy_q & ~bus.pcfg_g2f_interrupt_pulse) | pc_start_d;

        // A new done pulse overrides a concurrent write-1-to-clear.
        f2g_st_d  = (f2g_st_q  & ~f2g_w1c)  | bus.strm_f2g_interrupt_pulse;
        g2f_st_d  = (g2f_st_q  & ~g2f_w1c)  | bus.strm_g2f_interrupt_pulse;
        pcfg_st_d = (pcfg_st_q & ~pcfg_w1c) | bus.pcfg_g2f_interrupt_pulse;

        isr   = {|pcfg_st_q, |g2f_st_q, |f2g_st_q};
        irq_d = |(ier_q & isr);

        // Reads see the pre-edge state, so a W1C read in its write cycle
        // returns the value before clearing.
        rd_mux = '0;
        case (bus.cfg_rd_addr)
            ADDR_IER:       rd_mux[2:0]   = ier_q;
            ADDR_ISR:       rd_mux[2:0]   = isr;
            ADDR_F2G_ST:    rd_mux[N-1:0] = f2g_st_q;
            ADDR_G2F_ST:    rd_mux[N-1:0] = g2f_st_q;
            ADDR_PCFG_ST:   rd_mux[N-1:0] = pcfg_st_q;
            ADDR_STRM_BUSY: rd_mux[N-1:0] = strm_busy_q;
            ADDR_PC_BUSY:   rd_mux[N-1:0] = pc_busy_q;
            default: ;
        endcase
        rd_valid_d = bus.cfg_rd_en;
        rd_data_d  = bus.cfg_rd_en ? rd_mux : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ier_q        <= '0;
            f2g_st_q     <= '0;
            g2f_st_q     <= '0;
            pcfg_st_q    <= '0;
            strm_busy_q  <= '0;
            pc_busy_q    <= '0;
            strm_start_q <= '0;
            pc_start_q   <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            ier_q        <= ier_d;
            f2g_st_q     <= f2g_st_d;
            g2f_st_q     <= g2f_st_d;
            pcfg_st_q    <= pcfg_st_d;
            strm_busy_q  <= strm_busy_d;
            pc_busy_q    <= pc_busy_d;
            strm_start_q <= strm_start_d;
            pc_start_q   <= pc_start_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            irq_q        <= irq_d;
        end
    end

    assign bus.cfg_rd_data       = rd_data_q;
    assign bus.cfg_rd_data_valid = rd_valid_q;
    assign bus.strm_start_pulse  = strm_start_q;
    assign bus.pc_start_pulse    = pc_start_q;
    assign bus.interrupt         = irq_q;

endmodule
